// File: rtl/ofdm_sync_ctrl_if.sv
// Signal bundle between the OFDM sync sequencer and its environment: config handshake,
// detector strobes, framer output taps and per-packet status.
interface ofdm_sync_ctrl_if;
  logic [7:0]  cfg_num_symbols;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  num_symbols;
  logic        num_symbols_valid;
  logic        det_stb;
  logic        lp_stb;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic        clear;
  logic        busy;
  logic        done_stb;
  logic        len_err_stb;
  logic        timeout_stb;
  logic [15:0] pkt_count;

  modport master (
    output cfg_num_symbols, cfg_valid, det_stb, lp_stb, mon_tvalid, mon_tready, mon_tlast,
    input  cfg_ready, num_symbols, num_symbols_valid, clear, busy, done_stb, len_err_stb,
           timeout_stb, pkt_count
  );

  modport slave (
    input  cfg_num_symbols, cfg_valid, det_stb, lp_stb, mon_tvalid, mon_tready, mon_tlast,
    output cfg_ready, num_symbols, num_symbols_valid, clear, busy, done_stb, len_err_stb,
           timeout_stb, pkt_count
  );
endinterface

// File: rtl/ofdm_sync_ctrl.sv
// Per-packet sequencer for the OFDM receive synchroniser chain: config hand-off, detection
// tracking, framed symbol counting, timeouts, status strobes and a datapath clear pulse.
module ofdm_sync_ctrl #(
  parameter int unsigned SYMBOL_LEN     = 64,
  parameter int unsigned SEARCH_TIMEOUT = 1024,
  parameter int unsigned FRAME_TIMEOUT  = 4096,
  parameter int unsigned CLEAR_CYCLES   = 4
) (
  input logic             clk,
  input logic             reset,
  ofdm_sync_ctrl_if.slave bus
);

  // One timer serves both the search window and the frame idle watchdog.
  localparam int unsigned TMR_MAX = (SEARCH_TIMEOUT > FRAME_TIMEOUT) ?
                                    SEARCH_TIMEOUT - 1 : FRAME_TIMEOUT - 1;
  localparam int unsigned TW = $clog2(TMR_MAX) + 1;
  localparam int unsigned BW = $clog2(SYMBOL_LEN - 1) + 1;
  localparam int unsigned CW = $clog2(CLEAR_CYCLES - 1) + 1;

  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] FRAME_LAST  = TW'(FRAME_TIMEOUT - 1);
  localparam logic [BW-1:0] BEAT_LAST   = BW'(SYMBOL_LEN - 1);
  localparam logic [CW-1:0] CLEAR_LAST  = CW'(CLEAR_CYCLES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StArmed  = 3'd1;
  localparam logic [2:0] StSearch = 3'd2;
  localparam logic [2:0] StFrame  = 3'd3;
  localparam logic [2:0] StClear  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    num_symbols_q, num_symbols_d;
  logic          nsv_q, nsv_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [8:0]    sym_q, sym_d;
  logic [CW-1:0] clr_q, clr_d;
  logic          done_q, done_d;
  logic          len_err_q, len_err_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   pkt_q, pkt_d;

  logic       cfg_ready;
  logic       beat;
  logic       wrap;
  logic [8:0] exp_syms;
  logic [8:0] final_syms;

  assign cfg_ready  = (state_q == StIdle) & ~reset;
  assign beat       = bus.mon_tvalid & bus.mon_tready;
  assign wrap       = (beat_q == BEAT_LAST);
  // A configured count of zero stands for 256 symbols.
  assign exp_syms   = {num_symbols_q == 8'd0, num_symbols_q};
  assign final_syms = sym_q + {8'd0, wrap};

  always_comb begin
    state_d       = state_q;
    num_symbols_d = num_symbols_q;
    nsv_d         = nsv_q;
    timer_d       = timer_q;
    beat_d        = beat_q;
    sym_d         = sym_q;
    clr_d         = clr_q;
    pkt_d         = pkt_q;
    done_d        = 1'b0;
    len_err_d     = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cfg_valid && cfg_ready) begin
          num_symbols_d = bus.cfg_num_symbols;
          nsv_d         = 1'b1;
          state_d       = StArmed;
        end
      end
      StArmed: begin
        if (bus.det_stb) begin
          timer_d = '0;
          state_d = StSearch;
        end
      end
      StSearch: begin
        // Alignment on the last cycle of the window still counts.
        if (bus.lp_stb) begin
          timer_d = '0;
          beat_d  = '0;
          sym_d   = '0;
          state_d = StFrame;
        end else if (timer_q == SEARCH_LAST) begin
          timeout_d = 1'b1;
          state_d   = StClear;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StFrame: begin
        if (beat) begin
          timer_d = '0;
          if (bus.mon_tlast) begin
            if (wrap && (final_syms == exp_syms)) begin
              done_d = 1'b1;
              pkt_d  = pkt_q + 16'd1;
            end else begin
              len_err_d = 1'b1;
            end
            state_d = StClear;
          end else begin
            beat_d = wrap ? '0 : beat_q + 1'b1;
            sym_d  = final_syms;
          end
        end else if (timer_q == FRAME_LAST) begin
          timeout_d = 1'b1;
          state_d   = StClear;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StClear: begin
        if (clr_q == CLEAR_LAST) begin
          state_d = StIdle;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Entry into CLEAR: restart the pulse counter and withdraw the config.
    if ((state_q != StClear) && (state_d == StClear)) begin
      clr_d = '0;
      nsv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      num_symbols_q <= '0;
      nsv_q         <= 1'b0;
      timer_q       <= '0;
      beat_q        <= '0;
      sym_q         <= '0;
      clr_q         <= '0;
      done_q        <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
      pkt_q         <= '0;
    end else begin
      state_q       <= state_d;
      num_symbols_q <= num_symbols_d;
      nsv_q         <= nsv_d;
      timer_q       <= timer_d;
      beat_q        <= beat_d;
      sym_q         <= sym_d;
      clr_q         <= clr_d;
      done_q        <= done_d;
      len_err_q     <= len_err_d;
      timeout_q     <= timeout_d;
      pkt_q         <= pkt_d;
    end
  end

  assign bus.cfg_ready         = cfg_ready;
  assign bus.num_symbols       = num_symbols_q;
  assign bus.num_symbols_valid = nsv_q;
  assign bus.clear             = (state_q == StClear);
  assign bus.busy              = (state_q != StIdle);
  assign bus.done_stb          = done_q;
  assign bus.len_err_stb       = len_err_q;
  assign bus.timeout_stb       = timeout_q;
  assign bus.pkt_count         = pkt_q;

endmodule
